// File: rtl/render_frame_scheduler.sv
// Frame sequencer for the sphere-render pipeline: clears the frame buffer, streams particles
// to the projector, waits for the pipeline to drain, and arbitrates frame-buffer port A.
module render_frame_scheduler #(
  parameter int unsigned WIDTH     = 320,
  parameter int unsigned HEIGHT    = 180,
  parameter int unsigned FB_AW     = 16,
  parameter int unsigned P_AW      = 10,
  parameter int unsigned RD_LAT    = 2,
  parameter logic [15:0] BG_COLOR  = 16'h0000,
  parameter int unsigned DRAIN_MIN = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              frame_start_in,
  input  logic [P_AW:0]     num_particles_in,
  output logic [P_AW-1:0]   p_addr_out,
  input  logic [15:0]       p_x_in,
  input  logic [15:0]       p_y_in,
  input  logic [15:0]       p_z_in,
  output logic [15:0]       f_x_out,
  output logic [15:0]       f_y_out,
  output logic [15:0]       f_z_out,
  output logic              data_valid_out,
  input  logic              projector_ready_in,
  input  logic              pipeline_idle_in,
  input  logic [FB_AW-1:0]  pix_addr_in,
  input  logic [15:0]       pix_data_in,
  input  logic              pix_we_in,
  output logic [FB_AW-1:0]  fb_addr_out,
  output logic [15:0]       fb_data_out,
  output logic              fb_we_out,
  output logic              busy_out,
  output logic              frame_done_out,
  output logic              overrun_out,
  output logic              drop_err_out
);

  localparam int unsigned NPIX = WIDTH * HEIGHT;
  localparam int unsigned NW   = P_AW + 1;
  localparam int unsigned LW   = $clog2(RD_LAT + 1);
  localparam int unsigned DW   = $clog2(DRAIN_MIN + 2);
  localparam logic [NW-1:0]    N_MAX    = NW'(2 ** P_AW);
  localparam logic [FB_AW-1:0] LAST_PIX = FB_AW'(NPIX - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_WAIT, S_ISSUE, S_DRAIN, S_DONE
  } state_t;

  state_t           state;
  logic [FB_AW-1:0] clr_cnt;
  logic [NW-1:0]    n_reg;
  logic [LW-1:0]    wait_cnt;
  logic [DW-1:0]    drain_cnt;
  logic             idle_prev;
  logic             last_particle;
  logic             drain_min_met;

  // p_addr_out doubles as the particle index i
  assign last_particle = ({1'b0, p_addr_out} == (n_reg - NW'(1)));
  assign drain_min_met = (32'(drain_cnt) + 32'd1 >= DRAIN_MIN);

  // Port A: clear engine owns it during CLEAR, otherwise zero-latency pixel pass-through
  always_comb begin
    fb_addr_out = pix_addr_in;
    fb_data_out = pix_data_in;
    fb_we_out   = pix_we_in;
    if (state == S_CLEAR) begin
      fb_addr_out = clr_cnt;
      fb_data_out = BG_COLOR;
      fb_we_out   = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= S_IDLE;
      clr_cnt        <= '0;
      n_reg          <= '0;
      wait_cnt       <= '0;
      drain_cnt      <= '0;
      idle_prev      <= 1'b0;
      p_addr_out     <= '0;
      f_x_out        <= '0;
      f_y_out        <= '0;
      f_z_out        <= '0;
      data_valid_out <= 1'b0;
      busy_out       <= 1'b0;
      frame_done_out <= 1'b0;
      overrun_out    <= 1'b0;
      drop_err_out   <= 1'b0;
    end else begin
      frame_done_out <= 1'b0;
      overrun_out    <= frame_start_in && (state != S_IDLE);
      if (state == S_CLEAR && pix_we_in) drop_err_out <= 1'b1;

      case (state)
        S_IDLE: begin
          if (frame_start_in) begin
            n_reg      <= (num_particles_in > N_MAX) ? N_MAX : num_particles_in;
            clr_cnt    <= '0;
            p_addr_out <= '0;
            busy_out   <= 1'b1;
            state      <= S_CLEAR;
          end
        end

        S_CLEAR: begin
          if (clr_cnt == LAST_PIX) begin
            if (n_reg != '0) begin
              state <= S_FETCH;
            end else begin
              drain_cnt <= '0;
              idle_prev <= 1'b0;
              state     <= S_DRAIN;
            end
          end else begin
            clr_cnt <= clr_cnt + FB_AW'(1);
          end
        end

        S_FETCH: begin
          wait_cnt <= LW'(1);
          state    <= S_WAIT;
        end

        // RAM data is valid RD_LAT cycles after the FETCH cycle
        S_WAIT: begin
          if (wait_cnt == LW'(RD_LAT)) begin
            f_x_out        <= p_x_in;
            f_y_out        <= p_y_in;
            f_z_out        <= p_z_in;
            data_valid_out <= 1'b1;
            state          <= S_ISSUE;
          end else begin
            wait_cnt <= wait_cnt + LW'(1);
          end
        end

        S_ISSUE: begin
          if (projector_ready_in) begin
            data_valid_out <= 1'b0;
            if (last_particle) begin
              drain_cnt <= '0;
              idle_prev <= 1'b0;
              state     <= S_DRAIN;
            end else begin
              p_addr_out <= p_addr_out + P_AW'(1);
              state      <= S_FETCH;
            end
          end
        end

        // Idle must be seen on two consecutive DRAIN cycles after the minimum dwell
        S_DRAIN: begin
          idle_prev <= pipeline_idle_in;
          if (drain_cnt != DW'(DRAIN_MIN)) drain_cnt <= drain_cnt + DW'(1);
          if (drain_min_met && pipeline_idle_in && idle_prev) begin
            frame_done_out <= 1'b1;
            state          <= S_DONE;
          end
        end

        S_DONE: begin
          busy_out <= 1'b0;
          state    <= S_IDLE;
        end

        default: begin
          busy_out <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_render_frame_scheduler.sv
// Bench for render_frame_scheduler: directed scenarios plus randomized frames checked
// against event-level expectations (clear window, particle order, drain rule).
module tb_render_frame_scheduler;

  localparam int unsigned W = 4, H = 2, WH = W * H;
  localparam int unsigned FB_AW = 8, P_AW = 4, NW = P_AW + 1, NP = 2 ** P_AW;
  localparam int unsigned RD_LAT = 2, DRAIN_MIN = 4;
  localparam logic [15:0] BG = 16'h0841;
  localparam int HIST = 32768;

  typedef struct { int cyc; logic [15:0] x; logic [15:0] y; logic [15:0] z; logic [P_AW-1:0] a; } xfer_t;
  typedef struct { int cyc; logic [FB_AW-1:0] a; logic [15:0] d; } wr_t;

  logic clk = 1'b0;
  logic rst_in, frame_start_in, projector_ready_in, pipeline_idle_in, pix_we_in;
  logic [NW-1:0] num_particles_in;
  logic [P_AW-1:0] p_addr_out;
  logic [15:0] p_x_in, p_y_in, p_z_in, f_x_out, f_y_out, f_z_out, pix_data_in, fb_data_out;
  logic [FB_AW-1:0] pix_addr_in, fb_addr_out;
  logic data_valid_out, fb_we_out, busy_out, frame_done_out, overrun_out, drop_err_out;

  render_frame_scheduler #(
    .WIDTH(W), .HEIGHT(H), .FB_AW(FB_AW), .P_AW(P_AW), .RD_LAT(RD_LAT),
    .BG_COLOR(BG), .DRAIN_MIN(DRAIN_MIN)
  ) dut (
    .clk_in(clk), .rst_in(rst_in), .frame_start_in(frame_start_in),
    .num_particles_in(num_particles_in), .p_addr_out(p_addr_out),
    .p_x_in(p_x_in), .p_y_in(p_y_in), .p_z_in(p_z_in),
    .f_x_out(f_x_out), .f_y_out(f_y_out), .f_z_out(f_z_out),
    .data_valid_out(data_valid_out), .projector_ready_in(projector_ready_in),
    .pipeline_idle_in(pipeline_idle_in), .pix_addr_in(pix_addr_in),
    .pix_data_in(pix_data_in), .pix_we_in(pix_we_in),
    .fb_addr_out(fb_addr_out), .fb_data_out(fb_data_out), .fb_we_out(fb_we_out),
    .busy_out(busy_out), .frame_done_out(frame_done_out),
    .overrun_out(overrun_out), .drop_err_out(drop_err_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Particle RAM model with RD_LAT-cycle read latency
  logic [15:0] ram_x [NP], ram_y [NP], ram_z [NP];
  logic [15:0] px [RD_LAT], py [RD_LAT], pz [RD_LAT];
  always @(posedge clk) begin
    px[0] <= ram_x[p_addr_out];
    py[0] <= ram_y[p_addr_out];
    pz[0] <= ram_z[p_addr_out];
    for (int k = 1; k < int'(RD_LAT); k++) begin
      px[k] <= px[k-1];
      py[k] <= py[k-1];
      pz[k] <= pz[k-1];
    end
  end
  assign p_x_in = px[RD_LAT-1];
  assign p_y_in = py[RD_LAT-1];
  assign p_z_in = pz[RD_LAT-1];

  int n_cmp = 0, n_err = 0;
  bit rdy_rand = 0, idle_rand = 0;
  bit idle_hist [HIST];
  xfer_t xq [$];
  wr_t   wq [$];
  int    dq [$], oq [$];
  int    hold_viol = 0;

  // Event recorder, sampled mid-cycle
  initial begin
    xfer_t xr;
    wr_t wr;
    bit pv, pr;
    logic [15:0] pfx, pfy, pfz;
    pv = 0; pr = 0; pfx = 0; pfy = 0; pfz = 0;
    forever begin
      @(negedge clk);
      if (cyc < HIST) idle_hist[cyc] = pipeline_idle_in;
      if (data_valid_out && projector_ready_in) begin
        xr.cyc = cyc; xr.x = f_x_out; xr.y = f_y_out; xr.z = f_z_out; xr.a = p_addr_out;
        xq.push_back(xr);
      end
      if (fb_we_out) begin
        wr.cyc = cyc; wr.a = fb_addr_out; wr.d = fb_data_out;
        wq.push_back(wr);
      end
      if (frame_done_out) dq.push_back(cyc);
      if (overrun_out) oq.push_back(cyc);
      if (pv && !pr && !(data_valid_out && f_x_out == pfx && f_y_out == pfy && f_z_out == pfz))
        hold_viol++;
      pv = data_valid_out; pr = projector_ready_in | rst_in;
      pfx = f_x_out; pfy = f_y_out; pfz = f_z_out;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_rand) projector_ready_in = 1'($urandom_range(0, 1));
    if (idle_rand) pipeline_idle_in = 1'($urandom_range(0, 1));
  endtask

  task automatic start_frame(input int n, output int t);
    num_particles_in = NW'(n);
    frame_start_in = 1'b1;
    t = cyc;
    tick();
    frame_start_in = 1'b0;
  endtask

  task automatic wait_frame(input int budget);
    int n0;
    n0 = dq.size();
    for (int k = 0; k < budget && dq.size() == n0; k++) tick();
    n_cmp++;
    if (dq.size() == n0) begin
      n_err++;
      $display("FAIL frame_timeout: no frame_done_out within %0d cycles", budget);
    end
  endtask

  // Done fires in the first cycle >= DRAIN_MIN after drain entry that follows two idle drain cycles
  function automatic int exp_done(input int ds);
    for (int c = ds + 2; c <= cyc && c < HIST; c++)
      if (c >= ds + int'(DRAIN_MIN) && idle_hist[c-1] && idle_hist[c-2]) return c;
    return -1;
  endfunction

  task automatic load_ram_random();
    for (int k = 0; k < int'(NP); k++) begin
      ram_x[k] = 16'($urandom); ram_y[k] = 16'($urandom); ram_z[k] = 16'($urandom);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({busy_out, data_valid_out, frame_done_out, overrun_out, drop_err_out, fb_we_out} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 000000",
               {busy_out, data_valid_out, frame_done_out, overrun_out, drop_err_out, fb_we_out});
    end
    n_cmp++;
    if ({p_addr_out, f_x_out, f_y_out, f_z_out, fb_addr_out} !== '0) begin
      n_err++;
      $display("FAIL reset_data: p_addr=%h fx=%h fy=%h fz=%h fb_addr=%h want all 0",
               p_addr_out, f_x_out, f_y_out, f_z_out, fb_addr_out);
    end
    n_cmp++;
    if (fb_data_out !== 16'h0 && fb_data_out !== BG) begin
      n_err++;
      $display("FAIL reset_fb_data: got %h want 0 or %h", fb_data_out, BG);
    end
    rst_in = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if (busy_out !== 1'b0) begin
      n_err++;
      $display("FAIL idle_busy: got %b want 0", busy_out);
    end
  endtask

  task automatic test_clear();
    int t;
    xq.delete(); wq.delete(); dq.delete();
    start_frame(0, t);
    wait_frame(200);
    n_cmp++;
    if (wq.size() != WH) begin
      n_err++;
      $display("FAIL clear_count: got %0d writes want %0d", wq.size(), WH);
    end
    for (int k = 0; k < wq.size() && k < int'(WH); k++) begin
      n_cmp++;
      if (wq[k].a !== FB_AW'(k) || wq[k].d !== BG || wq[k].cyc != t + 1 + k) begin
        n_err++;
        $display("FAIL clear_write[%0d]: got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                 k, wq[k].a, wq[k].d, wq[k].cyc, k, BG, t + 1 + k);
      end
    end
    n_cmp++;
    if (dq.size() != 1 || dq[0] != t + int'(WH) + 1 + int'(DRAIN_MIN)) begin
      n_err++;
      $display("FAIL clear_done: got %0d pulses first=%0d want 1 at %0d", dq.size(),
               dq.size() > 0 ? dq[0] : -1, t + int'(WH) + 1 + int'(DRAIN_MIN));
    end
    n_cmp++;
    if (busy_out !== 1'b0) begin
      n_err++;
      $display("FAIL clear_busy_after: got %b want 0", busy_out);
    end
  endtask

  task automatic test_stream();
    int t;
    load_ram_random();
    for (int k = 0; k < 3; k++) begin
      ram_x[k] = 16'(3 * k + 1); ram_y[k] = 16'(3 * k + 2); ram_z[k] = 16'(3 * k + 3);
    end
    xq.delete(); wq.delete(); dq.delete();
    projector_ready_in = 1'b1; pipeline_idle_in = 1'b1;
    start_frame(3, t);
    wait_frame(300);
    n_cmp++;
    if (xq.size() != 3) begin
      n_err++;
      $display("FAIL stream_count: got %0d transfers want 3", xq.size());
    end
    for (int k = 0; k < xq.size() && k < 3; k++) begin
      n_cmp++;
      if (xq[k].x !== 16'(3*k+1) || xq[k].y !== 16'(3*k+2) || xq[k].z !== 16'(3*k+3) || xq[k].a !== P_AW'(k)) begin
        n_err++;
        $display("FAIL stream_xfer[%0d]: got (%0d,%0d,%0d) addr=%0d want (%0d,%0d,%0d) addr=%0d",
                 k, xq[k].x, xq[k].y, xq[k].z, xq[k].a, 3*k+1, 3*k+2, 3*k+3, k);
      end
      n_cmp++;
      // RD_LAT+1 cycles without valid between consecutive transfers
      if ((k == 0 && xq[k].cyc != t + int'(WH) + int'(RD_LAT) + 2) ||
          (k > 0 && xq[k].cyc - xq[k-1].cyc != int'(RD_LAT) + 2)) begin
        n_err++;
        $display("FAIL stream_timing[%0d]: got cyc=%0d (start %0d)", k, xq[k].cyc, t);
      end
    end
    n_cmp++;
    if (xq.size() == 3 && (dq.size() != 1 || dq[0] != exp_done(xq[2].cyc + 1))) begin
      n_err++;
      $display("FAIL stream_done: got %0d pulses want 1 at %0d", dq.size(), exp_done(xq[2].cyc + 1));
    end
  endtask

  task automatic test_backpressure();
    int t, c, hv0;
    bit found;
    load_ram_random();
    xq.delete(); wq.delete(); dq.delete();
    hv0 = hold_viol;
    projector_ready_in = 1'b1; pipeline_idle_in = 1'b1;
    start_frame(3, t);
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (data_valid_out && p_addr_out == P_AW'(1)) found = 1;
      else tick();
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL bp_issue1: got no ISSUE of particle 1 want one within 200 cycles");
    end
    c = cyc;
    projector_ready_in = 1'b0;
    repeat (5) tick();
    projector_ready_in = 1'b1;
    wait_frame(300);
    n_cmp++;
    if (xq.size() != 3) begin
      n_err++;
      $display("FAIL bp_count: got %0d transfers want 3", xq.size());
    end
    for (int k = 0; k < xq.size() && k < 3; k++) begin
      n_cmp++;
      if (xq[k].x !== ram_x[k] || xq[k].y !== ram_y[k] || xq[k].z !== ram_z[k] || xq[k].a !== P_AW'(k)) begin
        n_err++;
        $display("FAIL bp_xfer[%0d]: got (%h,%h,%h) want (%h,%h,%h)", k,
                 xq[k].x, xq[k].y, xq[k].z, ram_x[k], ram_y[k], ram_z[k]);
      end
    end
    n_cmp++;
    if (xq.size() > 1 && xq[1].cyc != c + 5) begin
      n_err++;
      $display("FAIL bp_release: got transfer at %0d want %0d", xq[1].cyc, c + 5);
    end
    n_cmp++;
    if (hold_viol != hv0) begin
      n_err++;
      $display("FAIL bp_hold: got %0d unstable stall cycles want 0", hold_viol - hv0);
    end
  endtask

  task automatic test_drain();
    int t, s;
    load_ram_random();
    xq.delete(); wq.delete(); dq.delete();
    projector_ready_in = 1'b1; pipeline_idle_in = 1'b0;
    start_frame(2, t);
    for (int k = 0; k < 200 && xq.size() < 2; k++) tick();
    s = (xq.size() == 2) ? xq[1].cyc : cyc;
    repeat (20) tick();
    pipeline_idle_in = 1'b1;
    wait_frame(100);
    repeat (3) tick();
    n_cmp++;
    if (dq.size() != 1 || dq[0] != s + 23 || dq[0] != exp_done(s + 1)) begin
      n_err++;
      $display("FAIL drain_done: got %0d pulses first=%0d want 1 at %0d",
               dq.size(), dq.size() > 0 ? dq[0] : -1, s + 23);
    end
  endtask

  task automatic test_overrun_drop();
    int t;
    load_ram_random();
    xq.delete(); wq.delete(); dq.delete(); oq.delete();
    projector_ready_in = 1'b1; pipeline_idle_in = 1'b1;
    n_cmp++;
    if (drop_err_out !== 1'b0) begin
      n_err++;
      $display("FAIL drop_pre: got %b want 0", drop_err_out);
    end
    start_frame(1, t);
    tick();
    pix_we_in = 1'b1; pix_addr_in = FB_AW'(5); pix_data_in = 16'hBEEF;
    #1;
    n_cmp++;
    if (fb_we_out !== 1'b1 || fb_addr_out !== FB_AW'(1) || fb_data_out !== BG) begin
      n_err++;
      $display("FAIL drop_port: got we=%b addr=%0d data=%h want we=1 addr=1 data=%h",
               fb_we_out, fb_addr_out, fb_data_out, BG);
    end
    tick();
    pix_we_in = 1'b0;
    frame_start_in = 1'b1; num_particles_in = NW'(7);
    tick();
    frame_start_in = 1'b0;
    n_cmp++;
    if (overrun_out !== 1'b1 || drop_err_out !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_pulse: got overrun=%b drop_err=%b want 1 1", overrun_out, drop_err_out);
    end
    wait_frame(300);
    n_cmp++;
    if (oq.size() != 1 || oq[0] != t + 4) begin
      n_err++;
      $display("FAIL overrun_once: got %0d pulses want 1 at %0d", oq.size(), t + 4);
    end
    n_cmp++;
    if (xq.size() != 1 || dq.size() != 1 || wq.size() != WH) begin
      n_err++;
      $display("FAIL overrun_frame: got xfers=%0d dones=%0d writes=%0d want 1 1 %0d",
               xq.size(), dq.size(), wq.size(), WH);
    end
    for (int k = 0; k < wq.size(); k++) begin
      n_cmp++;
      if (wq[k].d !== BG || wq[k].a !== FB_AW'(k)) begin
        n_err++;
        $display("FAIL drop_write[%0d]: got addr=%0d data=%h want addr=%0d data=%h", k, wq[k].a, wq[k].d, k, BG);
      end
    end
    n_cmp++;
    if (drop_err_out !== 1'b1) begin
      n_err++;
      $display("FAIL drop_sticky: got %b want 1", drop_err_out);
    end
  endtask

  task automatic test_passthrough();
    int t;
    logic [FB_AW-1:0] a;
    logic [15:0] d;
    load_ram_random();
    dq.delete(); oq.delete();
    projector_ready_in = 1'b0; pipeline_idle_in = 1'b1;
    start_frame(2, t);
    for (int k = 0; k < 100 && !data_valid_out; k++) tick();
    a = FB_AW'($urandom); d = 16'($urandom);
    pix_we_in = 1'b1; pix_addr_in = a; pix_data_in = d;
    #1;
    n_cmp++;
    if (fb_we_out !== 1'b1 || fb_addr_out !== a || fb_data_out !== d) begin
      n_err++;
      $display("FAIL pass_write: got we=%b addr=%h data=%h want 1 %h %h", fb_we_out, fb_addr_out, fb_data_out, a, d);
    end
    pix_we_in = 1'b0;
    #1;
    n_cmp++;
    if (fb_we_out !== 1'b0) begin
      n_err++;
      $display("FAIL pass_idle: got we=%b want 0", fb_we_out);
    end
    projector_ready_in = 1'b1;
    for (int k = 0; k < 200 && !frame_done_out; k++) tick();
    frame_start_in = 1'b1; num_particles_in = NW'(3);
    tick();
    frame_start_in = 1'b0;
    n_cmp++;
    if (overrun_out !== 1'b1 || busy_out !== 1'b0) begin
      n_err++;
      $display("FAIL done_overrun: got overrun=%b busy=%b want 1 0", overrun_out, busy_out);
    end
    repeat (3) tick();
    n_cmp++;
    if (busy_out !== 1'b0 || dq.size() != 1) begin
      n_err++;
      $display("FAIL done_no_queue: got busy=%b dones=%0d want 0 1", busy_out, dq.size());
    end
  endtask

  task automatic test_reset_mid();
    int t;
    load_ram_random();
    projector_ready_in = 1'b1; pipeline_idle_in = 1'b1;
    start_frame(2, t);
    for (int k = 0; k < 100 && !data_valid_out; k++) tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    n_cmp++;
    if ({data_valid_out, fb_we_out, busy_out, drop_err_out} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_mid: got valid=%b we=%b busy=%b drop=%b want 0 0 0 0",
               data_valid_out, fb_we_out, busy_out, drop_err_out);
    end
    xq.delete(); wq.delete(); dq.delete();
    start_frame(1, t);
    wait_frame(200);
    n_cmp++;
    if (wq.size() != WH || wq[0].a !== '0 || wq[0].cyc != t + 1) begin
      n_err++;
      $display("FAIL reset_restart: got writes=%0d first_addr=%0d first_cyc=%0d want %0d 0 %0d",
               wq.size(), wq.size() > 0 ? wq[0].a : '1, wq.size() > 0 ? wq[0].cyc : -1, WH, t + 1);
    end
  endtask

  task automatic test_random_frames();
    int t, n, ne, ds, hv0;
    hv0 = hold_viol;
    for (int f = 0; f < 6; f++) begin
      n = (f == 3) ? 31 : int'($urandom_range(1, 5));
      ne = (n > int'(NP)) ? int'(NP) : n;
      load_ram_random();
      xq.delete(); wq.delete(); dq.delete();
      rdy_rand = 1; idle_rand = 1;
      start_frame(n, t);
      wait_frame(3000);
      rdy_rand = 0; idle_rand = 0;
      projector_ready_in = 1'b1; pipeline_idle_in = 1'b1;
      n_cmp++;
      if (xq.size() != ne) begin
        n_err++;
        $display("FAIL rand_count[%0d]: got %0d transfers want %0d (requested %0d)", f, xq.size(), ne, n);
      end
      for (int k = 0; k < xq.size() && k < ne; k++) begin
        n_cmp++;
        if (xq[k].x !== ram_x[k] || xq[k].y !== ram_y[k] || xq[k].z !== ram_z[k] || xq[k].a !== P_AW'(k) ||
            (k > 0 && xq[k].cyc - xq[k-1].cyc < int'(RD_LAT) + 2)) begin
          n_err++;
          $display("FAIL rand_xfer[%0d.%0d]: got (%h,%h,%h) addr=%0d cyc=%0d want (%h,%h,%h) addr=%0d",
                   f, k, xq[k].x, xq[k].y, xq[k].z, xq[k].a, xq[k].cyc, ram_x[k], ram_y[k], ram_z[k], k);
        end
      end
      n_cmp++;
      if (wq.size() != WH || wq[0].cyc != t + 1 || wq[WH-1].cyc != t + int'(WH)) begin
        n_err++;
        $display("FAIL rand_clear[%0d]: got %0d writes want %0d in cycles %0d..%0d", f, wq.size(), WH, t + 1, t + int'(WH));
      end
      ds = (xq.size() > 0) ? xq[xq.size()-1].cyc + 1 : t + int'(WH) + 1;
      n_cmp++;
      if (dq.size() != 1 || dq[0] != exp_done(ds)) begin
        n_err++;
        $display("FAIL rand_done[%0d]: got %0d pulses first=%0d want 1 at %0d",
                 f, dq.size(), dq.size() > 0 ? dq[0] : -1, exp_done(ds));
      end
      repeat (2) tick();
    end
    n_cmp++;
    if (hold_viol != hv0) begin
      n_err++;
      $display("FAIL rand_hold: got %0d unstable stall cycles want 0", hold_viol - hv0);
    end
  endtask

  initial begin
    rst_in = 1'b1; frame_start_in = 1'b0; num_particles_in = '0;
    projector_ready_in = 1'b1; pipeline_idle_in = 1'b1;
    pix_addr_in = '0; pix_data_in = '0; pix_we_in = 1'b0;
    load_ram_random();
    test_reset();
    test_clear();
    test_stream();
    test_backpressure();
    test_drain();
    test_overrun_drop();
    test_passthrough();
    test_reset_mid();
    test_random_frames();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
